decomp_fetch_ctrl: RTL and testbench

- Decompressor fetch/control unit between instruction memory and the instruction decoder.
- Walks the compressed halfword stream held in imem and expands each 8-bit token through the external token table.
- Passes escaped raw 32-bit instructions through unchanged.
- Presents one full instruction at a time to the decoder over a valid/ready handshake; the decoder stall (hazard unit) drives ready.

---
 rtl/decomp_pkg.sv | 31 +++
 rtl/decomp_hw_sel.sv | 17 +
 rtl/decomp_fetch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_decomp_fetch_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/decomp_pkg.sv
// Shared types and encodings for the instruction decompressor fetch unit.
package decomp_pkg;

    typedef enum logic [2:0] {
        S_RUN,
        S_LOOK,
        S_ESC_LO,
        S_ESC_HI,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        HW_TOK,
        HW_ESC,
        HW_ILL
    } hw_cls_t;

    localparam int         HW_W     = 16;
    localparam logic [7:0] ESC_MARK = 8'hFF;
    localparam logic [7:0] TOK_MARK = 8'h00;

    function automatic hw_cls_t classify_hw(input logic [HW_W-1:0] hw);
        if (hw[15:8] == ESC_MARK)
            return HW_ESC;
        else if (hw[15:8] == TOK_MARK)
            return HW_TOK;
        else
            return HW_ILL;
    endfunction

endpackage

// File: rtl/decomp_hw_sel.sv
// Picks the current halfword out of the fetched word and classifies it.
module decomp_hw_sel
    import decomp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_sel,
    output logic [HW_W-1:0]  o_hw,
    output hw_cls_t          o_cls
);

    // Low halfword comes first in the stream.
    assign o_hw  = i_sel ? i_word[2*HW_W-1:HW_W] : i_word[HW_W-1:0];
    assign o_cls = classify_hw(o_hw);

endmodule

// File: rtl/decomp_fetch_ctrl.sv
// Fetch/control unit: walks the compressed halfword stream, expands tokens
// through the token table and hands full instructions to the decoder.
module decomp_fetch_ctrl
    import decomp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 22,
    parameter int TOK_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WIDTH-1:0]  imem_rd,
    output logic              tt_en,
    output logic [TOK_W-1:0]  tt_addr,
    input  logic [WIDTH-1:0]  tt_rd,
    input  logic              redirect,
    input  logic [ADDR_W:0]   redirect_pc,
    output logic [WIDTH-1:0]  out_instr,
    output logic [ADDR_W:0]   out_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_hpc;
    logic [ADDR_W:0]   r_start_pc;
    logic [HW_W-1:0]   r_lo;
    logic [TOK_W-1:0]  r_tt_addr;
    logic              r_tt_en;
    logic [WIDTH-1:0]  r_out_instr;
    logic [ADDR_W:0]   r_out_pc;
    logic              r_out_valid;
    logic              r_err;

    logic [HW_W-1:0]   w_hw;
    hw_cls_t           w_cls;
    logic              w_free;
    logic              w_adv;
    logic              w_start_ld;
    logic              w_tok_start;
    logic              w_lo_ld;
    logic              w_set_err;
    logic              w_out_ld;
    logic [WIDTH-1:0]  w_out_data;

    decomp_hw_sel #(
        .WIDTH (WIDTH)
    ) u_hw_sel (
        .i_word (imem_rd),
        .i_sel  (r_hpc[0]),
        .o_hw   (w_hw),
        .o_cls  (w_cls)
    );

    assign w_free = !r_out_valid || out_ready;

    always_comb begin
        w_next      = r_state;
        w_adv       = 1'b0;
        w_start_ld  = 1'b0;
        w_tok_start = 1'b0;
        w_lo_ld     = 1'b0;
        w_set_err   = 1'b0;
        w_out_ld    = 1'b0;
        w_out_data  = '0;
        case (r_state)
            S_RUN: begin
                w_start_ld = 1'b1;
                case (w_cls)
                    HW_TOK: begin
                        w_adv       = 1'b1;
                        w_tok_start = 1'b1;
                        w_next      = S_LOOK;
                    end
                    HW_ESC: begin
                        w_adv  = 1'b1;
                        w_next = S_ESC_LO;
                    end
                    default: begin
                        w_set_err = 1'b1;
                        w_next    = S_HALT;
                    end
                endcase
            end
            S_LOOK: begin
                if (w_free) begin
                    w_out_ld   = 1'b1;
                    w_out_data = tt_rd;
                    w_next     = S_RUN;
                end
            end
            S_ESC_LO: begin
                w_lo_ld = 1'b1;
                w_adv   = 1'b1;
                w_next  = S_ESC_HI;
            end
            S_ESC_HI: begin
                if (w_free) begin
                    w_out_ld   = 1'b1;
                    w_out_data = WIDTH'({w_hw, r_lo});
                    w_adv      = 1'b1;
                    w_next     = S_RUN;
                end
            end
            default: w_next = r_state;
        endcase
        // A flush abandons whatever lookup or escape was in progress.
        if (redirect) begin
            w_next = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_RUN;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hpc       <= '0;
            r_start_pc  <= '0;
            r_lo        <= '0;
            r_tt_addr   <= '0;
            r_tt_en     <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else if (redirect) begin
            r_hpc       <= redirect_pc;
            r_tt_en     <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_adv)
                r_hpc <= r_hpc + {{ADDR_W{1'b0}}, 1'b1};
            if (w_start_ld)
                r_start_pc <= r_hpc;
            if (w_tok_start)
                r_tt_addr <= w_hw[TOK_W-1:0];
            r_tt_en <= (w_next == S_LOOK);
            if (w_lo_ld)
                r_lo <= w_hw;
            if (w_set_err)
                r_err <= 1'b1;
            if (w_out_ld) begin
                r_out_instr <= w_out_data;
                r_out_pc    <= r_start_pc;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign imem_addr = r_hpc[ADDR_W:1];
    assign tt_en     = r_tt_en;
    assign tt_addr   = r_tt_addr;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign out_valid = r_out_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_decomp_fetch_ctrl.sv
// Scoreboard bench for decomp_fetch_ctrl with small imem and token-table models.
module tb_decomp_fetch_ctrl;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 22;
    localparam int TOK_W  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              redirect = 1'b0;
    logic [ADDR_W:0]   redirect_pc = '0;
    logic              out_ready = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [WIDTH-1:0]  imem_rd;
    logic              tt_en;
    logic [TOK_W-1:0]  tt_addr;
    logic [WIDTH-1:0]  tt_rd;
    logic [WIDTH-1:0]  out_instr;
    logic [ADDR_W:0]   out_pc;
    logic              out_valid;
    logic              err;

    logic [31:0] imem [0:15];
    logic [31:0] tt   [0:255];

    typedef struct packed {
        logic [31:0]     instr;
        logic [ADDR_W:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_err    = 0;

    decomp_fetch_ctrl #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .TOK_W  (TOK_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .tt_en       (tt_en),
        .tt_addr     (tt_addr),
        .tt_rd       (tt_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    assign imem_rd = (imem_addr < 22'd16) ? imem[imem_addr[3:0]] : 32'h1234_1234;
    assign tt_rd   = tt[tt_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [ADDR_W:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 64'(sb.size()), 64'd1);
            end else begin
                m_e = sb.pop_front();
                chk("sb_instr", out_instr, m_e.instr);
                chk("sb_pc", out_pc, m_e.pc);
            end
        end
    end

    task automatic hold_reset();
        reset     = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        sb.delete();
        for (int i = 0; i < 16; i++) imem[i] = 32'h1234_1234;
        chk("rst_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_tt_en", tt_en, 0);
        chk("rst_tt_addr", tt_addr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_imem_addr", imem_addr, 0);
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 64'(sb.size()), 0);
    endtask

    task automatic load_base_stream();
        imem[0] = 32'h0007_0003;
        imem[1] = 32'h1005_FF00;
        imem[2] = 32'h0001_E3A0;
        push(32'hE081_2002, 0);
        push(32'hE283_3001, 1);
        push(32'hE3A0_1005, 2);
        push(32'hE1A0_0000, 5);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tt[i] = 32'h0;
        tt[1] = 32'hE1A0_0000;
        tt[3] = 32'hE081_2002;
        tt[7] = 32'hE283_3001;

        // Tokens, straddling escape, then halt on the trailing illegal halfword
        hold_reset();
        load_base_stream();
        reset = 1'b1;
        @(posedge clk); #1 chk("t1_valid_c1", out_valid, 0);
        @(posedge clk); #1 chk("t1_valid_c2", out_valid, 1);
        @(posedge clk); #1 chk("t1_valid_c3", out_valid, 0);
        @(posedge clk); #1 chk("t1_valid_c4", out_valid, 1);
        drain("t1_drain", 40);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_err", err, 1);
        chk("t1_halt_valid", out_valid, 0);
        chk("t1_halt_addr", imem_addr, 3);

        // Backpressure
        hold_reset();
        load_base_stream();
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1 chk("bp_valid_c1", out_valid, 0);
        @(posedge clk); #1;
        chk("bp_valid_c2", out_valid, 1);
        chk("bp_instr_c2", out_instr, 32'hE081_2002);
        chk("bp_pc_c2", out_pc, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_instr", out_instr, 32'hE081_2002);
            chk("bp_hold_pc", out_pc, 0);
            chk("bp_hold_tt_addr", tt_addr, 7);
            chk("bp_hold_tt_en", tt_en, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_instr", out_instr, 32'hE283_3001);
        chk("bp_next_pc", out_pc, 1);
        drain("bp_drain", 40);

        // Illegal halfword, then redirect recovers
        hold_reset();
        imem[0] = 32'h0000_1234;
        imem[1] = 32'h1234_0003;
        push(32'hE081_2002, 2);
        reset = 1'b1;
        @(posedge clk); #1 chk("ill_err_c1", err, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("ill_err", err, 1);
        chk("ill_valid", out_valid, 0);
        chk("ill_addr_frozen", imem_addr, 0);
        redirect    = 1'b1;
        redirect_pc = 23'd2;
        @(posedge clk); #1;
        redirect = 1'b0;
        chk("ill_redir_err", err, 0);
        chk("ill_redir_addr", imem_addr, 1);
        drain("ill_drain", 20);
        repeat (3) @(posedge clk);
        #1;
        chk("ill_err_again", err, 1);

        // Redirect while a lookup is pending
        hold_reset();
        imem[0] = 32'h0007_0003;
        imem[1] = 32'h1005_FF00;
        imem[2] = 32'h0001_0007;
        push(32'hE283_3001, 4);
        push(32'hE1A0_0000, 5);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rl_tt_en", tt_en, 1);
        chk("rl_tt_addr", tt_addr, 3);
        redirect    = 1'b1;
        redirect_pc = 23'd4;
        @(posedge clk); #1;
        redirect = 1'b0;
        chk("rl_valid_c2", out_valid, 0);
        chk("rl_addr", imem_addr, 2);
        @(posedge clk); #1 chk("rl_valid_c3", out_valid, 0);
        drain("rl_drain", 20);

        // Reset while the escape's high half is pending
        hold_reset();
        imem[0] = 32'h1005_FF00;
        imem[1] = 32'h0003_E3A0;
        push(32'hE3A0_1005, 0);
        push(32'hE081_2002, 3);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("re_addr_esc_hi", imem_addr, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("re_valid", out_valid, 0);
        chk("re_addr", imem_addr, 0);
        reset = 1'b1;
        drain("re_drain", 30);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
